// File: rtl/cell_pos_access_ctrl_if.sv
// Bundle of request, stream and RAM-port signals around one cell position RAM.
// The slave side is the access controller; the master side is the client plus the RAM.
interface cell_pos_access_ctrl_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  rd_start;
  logic                  rd_busy;
  logic                  rd_done;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH-1:0] rd_pid;
  logic [ADDR_WIDTH-1:0] particle_count;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ack;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_q;

  modport slave (
    input  rd_start, wr_req, wr_addr, wr_data, mem_q,
    output rd_busy, rd_done, rd_valid, rd_data, rd_pid, particle_count,
           wr_ack, mem_address, mem_data, mem_rden, mem_wren
  );

  modport master (
    output rd_start, wr_req, wr_addr, wr_data, mem_q,
    input  rd_busy, rd_done, rd_valid, rd_data, rd_pid, particle_count,
           wr_ack, mem_address, mem_data, mem_rden, mem_wren
  );
endinterface

// File: rtl/cell_pos_access_ctrl.sv
// Single-port cell position RAM sequencer: streams word 0 (count) then particles 1..count,
// with motion-update writes taking fixed priority over every read-issue slot.
module cell_pos_access_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input logic                   clk,
  input logic                   rst,
  cell_pos_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RCNT,
    S_WCNT,
    S_STRM,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  function automatic logic [ADDR_WIDTH-1:0] sat_count(input logic [ADDR_WIDTH-1:0] raw);
    return (raw > CNT_MAX) ? CNT_MAX : raw;
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  vld_p1_q, vld_p1_d, tag_p1_q, tag_p1_d;
  logic                  vld_p2_q, vld_p2_d, tag_p2_q, tag_p2_d;
  logic [ADDR_WIDTH-1:0] addr_p1_q, addr_p1_d, addr_p2_q, addr_p2_d;

  logic                  wr_go;
  logic                  rd_issue;
  logic                  rd_is_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] cnt_ret;
  logic                  stream_vld;

  assign wr_go = bus.wr_req;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_issue  = 1'b0;
    rd_is_cnt = 1'b0;
    rd_addr   = '0;
    cnt_ret   = sat_count(bus.mem_q[ADDR_WIDTH-1:0]);
    // busy covers the rd_done cycle itself, then drops
    if (done_q) busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rd_start && !busy_q) begin
          state_d = S_RCNT;
          busy_d  = 1'b1;
        end
      end
      S_RCNT: begin
        if (!wr_go) begin
          rd_issue  = 1'b1;
          rd_is_cnt = 1'b1;
          state_d   = S_WCNT;
        end
      end
      S_WCNT: begin
        if (vld_p2_q && tag_p2_q) begin
          cnt_d = cnt_ret;
          if (cnt_ret == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d   = ADDR_WIDTH'(1);
            state_d = S_STRM;
          end
        end
      end
      S_STRM: begin
        if (!wr_go) begin
          rd_issue = 1'b1;
          rd_addr  = ptr_q;
          ptr_d    = ptr_q + ADDR_WIDTH'(1);
          if (ptr_q == cnt_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // the last issued read is in stage 2 once stage 1 empties
        if (!vld_p1_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // issue -> p1 (RAM internal register) -> p2 (mem_q valid)
  always_comb begin
    vld_p1_d  = rd_issue;
    tag_p1_d  = rd_is_cnt;
    addr_p1_d = rd_addr;
    vld_p2_d  = vld_p1_q;
    tag_p2_d  = tag_p1_q;
    addr_p2_d = addr_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_p1_q  <= 1'b0;
      tag_p1_q  <= 1'b0;
      addr_p1_q <= '0;
      vld_p2_q  <= 1'b0;
      tag_p2_q  <= 1'b0;
      addr_p2_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_p1_q  <= vld_p1_d;
      tag_p1_q  <= tag_p1_d;
      addr_p1_q <= addr_p1_d;
      vld_p2_q  <= vld_p2_d;
      tag_p2_q  <= tag_p2_d;
      addr_p2_q <= addr_p2_d;
    end
  end

  assign stream_vld         = vld_p2_q && !tag_p2_q;
  assign bus.rd_valid       = stream_vld;
  assign bus.rd_pid         = addr_p2_q;
  assign bus.rd_data        = stream_vld ? bus.mem_q : {DATA_WIDTH{1'b0}};
  assign bus.rd_busy        = busy_q;
  assign bus.rd_done        = done_q;
  assign bus.particle_count = cnt_q;

  assign bus.wr_ack      = wr_go;
  assign bus.mem_wren    = wr_go;
  assign bus.mem_rden    = rd_issue;
  assign bus.mem_address = wr_go ? bus.wr_addr : rd_addr;
  assign bus.mem_data    = wr_go ? bus.wr_data : {DATA_WIDTH{1'b0}};

endmodule
